// File: rtl/button_cmd_scheduler_pkg.sv
// Shared constants for the button command path: FSM encodings and default
// auto-repeat timing (kept in step with the debounce clock-divider settings).
package button_cmd_scheduler_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

endpackage

// File: rtl/button_cmd_scheduler_if.sv
// Single-command valid/ready port between the scheduler and the mode/drive FSM.
interface button_cmd_scheduler_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_id;
  logic           cmd_repeat;

  modport master (
    output cmd_valid,
    output cmd_id,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/button_cmd_scheduler_repeat_timer.sv
// Shared auto-repeat timer: armed by a fresh press, ticks while that button
// stays held, first after DELAY cycles then every PERIOD cycles.
module repeat_timer #(
  parameter int unsigned IDW    = 2,
  parameter int unsigned DELAY  = 50_000_000,
  parameter int unsigned PERIOD = 10_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic [IDW-1:0] arm_id,
  input  logic           hold,
  output logic           tick,
  output logic [IDW-1:0] rep_id
);
  localparam int unsigned MAXV = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int unsigned CW   = $clog2(MAXV + 1);

  logic          armed;
  logic [CW-1:0] count;

  // A re-arm in the same cycle pre-empts any tick of the old channel.
  assign tick = armed && hold && (count == CW'(1)) && !arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed  <= 1'b0;
      count  <= '0;
      rep_id <= '0;
    end else if (arm && (DELAY != 0)) begin
      armed  <= 1'b1;
      rep_id <= arm_id;
      count  <= CW'(DELAY);
    end else if (armed) begin
      if (!hold) begin
        armed <= 1'b0;
      end else if (count == CW'(1)) begin
        count <= CW'(PERIOD);
      end else begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: rtl/button_cmd_scheduler.sv
// Collects one-pulsed button events as pending requests and issues them one at
// a time on a valid/ready command port, round-robin, with auto-repeat on hold.
module button_cmd_scheduler
  import button_cmd_scheduler_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            pb_db,
  input  logic [N-1:0]            pb_op,
  button_cmd_scheduler_if.master  cmd,
  output logic                    drop,
  input  logic                    drop_clr
);
  localparam int unsigned IDW = $clog2(N);

  logic [0:0]     state;
  logic [N-1:0]   pending, pend_rep;
  logic [IDW-1:0] rr_ptr;
  logic           cmd_valid_q, cmd_repeat_q;
  logic [IDW-1:0] cmd_id_q;

  logic           tick, hold;
  logic [IDW-1:0] rep_id, grant_idx, arm_id;
  logic [N-1:0]   grant_vec, rep_vec, rep_set;
  logic           do_grant, drop_set;

  // Circular search from ptr; iterating downward leaves the nearest hit last.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0] sel;
    int unsigned    idx;
    sel = ptr;
    for (int unsigned k = N; k > 0; k--) begin
      idx = (int'(ptr) + k - 1) % N;
      if (req[idx]) sel = IDW'(idx);
    end
    return sel;
  endfunction

  function automatic logic [IDW-1:0] lowest_set(input logic [N-1:0] v);
    logic [IDW-1:0] sel;
    sel = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (v[k-1]) sel = IDW'(k - 1);
    end
    return sel;
  endfunction

  assign arm_id = lowest_set(pb_op);
  assign hold   = pb_db[rep_id];

  repeat_timer #(
    .IDW    (IDW),
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .arm    (|pb_op),
    .arm_id (arm_id),
    .hold   (hold),
    .tick   (tick),
    .rep_id (rep_id)
  );

  always_comb begin
    grant_idx = rr_pick(pending, rr_ptr);
    do_grant  = (state == ST_IDLE) && (|pending);
    grant_vec = '0;
    if (do_grant) grant_vec[grant_idx] = 1'b1;
    rep_vec = '0;
    if (tick) rep_vec[rep_id] = 1'b1;
    rep_set  = rep_vec & ~pending;
    drop_set = |(pb_op & pending & ~grant_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      pend_rep     <= '0;
      rr_ptr       <= '0;
      state        <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      cmd_repeat_q <= 1'b0;
      drop         <= 1'b0;
    end else begin
      // A set on the channel being granted overrides the grant's clear.
      pending  <= (pending & ~grant_vec) | pb_op | rep_set;
      pend_rep <= (pend_rep | rep_set) & ~pb_op;

      if (drop_set)      drop <= 1'b1;
      else if (drop_clr) drop <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            cmd_id_q     <= grant_idx;
            cmd_repeat_q <= pend_rep[grant_idx];
            cmd_valid_q  <= 1'b1;
            state        <= ST_OFFER;
          end
        end
        default: begin
          if (cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rr_ptr      <= (cmd_id_q == IDW'(N - 1)) ? '0 : cmd_id_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_id     = cmd_id_q;
  assign cmd.cmd_repeat = cmd_repeat_q;
endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler: scoreboard of expected commands plus
// cycle-exact checks of arbitration, drop, auto-repeat and reset behaviour.
module tb_button_cmd_scheduler;
  localparam int N = 4;
  localparam int D = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pb_db, pb_op;
  logic         drop, drop_clr;

  button_cmd_scheduler_if #(.N(N)) cmd_if ();

  button_cmd_scheduler #(
    .N             (N),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_db    (pb_db),
    .pb_op    (pb_op),
    .cmd      (cmd_if),
    .drop     (drop),
    .drop_clr (drop_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       rep;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic s_valid, s_rep, s_drop;
  logic [1:0] s_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sample the current cycle at the falling edge, then advance past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    s_valid = cmd_if.cmd_valid;
    s_id    = cmd_if.cmd_id;
    s_rep   = cmd_if.cmd_repeat;
    s_drop  = drop;
    if (s_valid && cmd_if.cmd_ready) begin
      hs_cyc.push_back(cnt);
      check("cmd_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_id", 32'(s_id), 32'(e.id));
        check("sb_rep", 32'(s_rep), 32'(e.rep));
      end
    end
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    pb_op = v;
    cyc();
    pb_op = '0;
  endtask

  task automatic push(input logic [1:0] id, input logic rep);
    exp_t e;
    e.id  = id;
    e.rep = rep;
    sb.push_back(e);
  endtask

  initial begin
    int t0, base;
    logic [7:0] exp_v;
    logic [1:0] exp_ids [0:7];
    int d4 [0:4];
    int d5 [0:2];

    rst = 1'b1; pb_db = '0; pb_op = '0; drop_clr = 1'b0; cmd_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_id", 32'(cmd_if.cmd_id), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst = 1'b0;

    // Single press on channel 2.
    cmd_if.cmd_ready = 1'b1;
    push(2'd2, 1'b0);
    pulse(4'b0100);
    check("t1_valid_t0", 32'(s_valid), 32'd0);
    cyc();
    check("t1_valid_t1", 32'(s_valid), 32'd0);
    cyc();
    check("t1_valid_t2", 32'(s_valid), 32'd1);
    check("t1_id_t2", 32'(s_id), 32'd2);
    check("t1_rep_t2", 32'(s_rep), 32'd0);
    cyc();
    check("t1_valid_t3", 32'(s_valid), 32'd0);
    check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd3);

    // Three simultaneous presses, round-robin from 3.
    push(2'd3, 1'b0); push(2'd0, 1'b0); push(2'd1, 1'b0);
    exp_v = 8'b0101_0100;
    exp_ids[2] = 2'd3; exp_ids[4] = 2'd0; exp_ids[6] = 2'd1;
    pulse(4'b1011);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      check($sformatf("t2_valid_%0d", i), 32'(s_valid), 32'(exp_v[i]));
      if (exp_v[i]) check($sformatf("t2_id_%0d", i), 32'(s_id), 32'(exp_ids[i]));
    end

    // Stalled offer on channel 1, re-press, drop and clear.
    cmd_if.cmd_ready = 1'b0;
    push(2'd1, 1'b0); push(2'd1, 1'b0);
    pulse(4'b0010);
    cyc();
    cyc();
    check("t3_valid_start", 32'(s_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      pb_op    = (k == 3 || k == 6) ? 4'b0010 : 4'b0000;
      drop_clr = (k == 8);
      cyc();
      pb_op    = '0;
      drop_clr = 1'b0;
      check($sformatf("t3_valid_%0d", k), 32'(s_valid), 32'd1);
      check($sformatf("t3_id_%0d", k), 32'(s_id), 32'd1);
      if (k == 4) begin
        check("t3_pending1", 32'(dut.pending[1]), 32'd1);
        check("t3_no_drop", 32'(s_drop), 32'd0);
      end
      if (k == 7) check("t3_drop_set", 32'(s_drop), 32'd1);
      if (k == 9) check("t3_drop_clr", 32'(s_drop), 32'd0);
    end
    cmd_if.cmd_ready = 1'b1;
    repeat (6) cyc();
    check("t3_drained", 32'(sb.size()), 32'd0);

    // Auto-repeat on channel 0.
    base = hs_cyc.size();
    push(2'd0, 1'b0);
    repeat (4) push(2'd0, 1'b1);
    d4[0] = 2; d4[1] = 10; d4[2] = 14; d4[3] = 18; d4[4] = 22;
    t0 = cnt;
    pb_db = 4'b0001;
    pulse(4'b0001);
    repeat (20) cyc();
    pb_db = '0;
    repeat (12) cyc();
    check("t4_count", 32'(hs_cyc.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < hs_cyc.size())
        check($sformatf("t4_cycle_%0d", i), 32'(hs_cyc[base+i] - t0), 32'(d4[i]));

    // Press on 1 while 2 is held re-arms the timer on 1.
    base = hs_cyc.size();
    push(2'd2, 1'b0); push(2'd1, 1'b0); push(2'd1, 1'b1);
    d5[0] = 2; d5[1] = 7; d5[2] = 15;
    t0 = cnt;
    pb_db = 4'b0100;
    pulse(4'b0100);
    repeat (4) cyc();
    pb_db = 4'b0110;
    pulse(4'b0010);
    check("t5_rep_id", 32'(dut.u_timer.rep_id), 32'd1);
    repeat (8) cyc();
    pb_db = '0;
    repeat (12) cyc();
    check("t5_count", 32'(hs_cyc.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < hs_cyc.size())
        check($sformatf("t5_cycle_%0d", i), 32'(hs_cyc[base+i] - t0), 32'(d5[i]));

    // Reset during an offer with other channels pending.
    cmd_if.cmd_ready = 1'b0;
    pulse(4'b0010);
    cyc();
    pulse(4'b0110);
    pulse(4'b0010);
    cyc();
    check("t6_valid_pre", 32'(s_valid), 32'd1);
    check("t6_drop_pre", 32'(s_drop), 32'd1);
    check("t6_pending_pre", 32'(dut.pending), 32'h6);
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("t6_id", 32'(cmd_if.cmd_id), 32'd0);
    check("t6_rep", 32'(cmd_if.cmd_repeat), 32'd0);
    check("t6_drop", 32'(drop), 32'd0);
    check("t6_pending", 32'(dut.pending), 32'd0);
    check("t6_state", 32'(dut.state), 32'd0);
    check("t6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    base = hs_cyc.size();
    repeat (10) cyc();
    check("t6_no_cmd", 32'(hs_cyc.size() - base), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/button_cmd_scheduler.md
Name: button_cmd_scheduler

Overview:
- Collects one-pulsed button events from an N-wide onepulse bank and holds them as pending requests.
- Shares a single command port between the buttons using round-robin arbitration and a valid/ready handshake.
- Generates auto-repeat events while the most recently pressed button stays held.
- Sits between the debounce/onepulse front end and the top-level mode/drive FSM, which consumes one command at a time.

Parameters:
- N, 4, number of button channels; must be >= 2.
- REPEAT_DELAY, 50_000_000, hold cycles before the first repeat; 0 disables auto-repeat.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeats; must be >= 1.
- IDW, $clog2(N), width of cmd_id (derived localparam, not overridable).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pb_db  in  N  debounced button levels
- pb_op  in  N  one-cycle press pulses, aligned to clk
- cmd_valid  out  1  command offered to consumer
- cmd_ready  in  1  consumer accepts the command this cycle
- cmd_id  out  IDW  index of the button granted
- cmd_repeat  out  1  1 = command came from auto-repeat, 0 = fresh press
- drop  out  1  sticky flag: an event was lost because its channel was already pending
- drop_clr  in  1  clears drop

Behaviour:
- Reset (async, rst=1) clears everything: pending=0, pend_rep=0, rr_ptr=0, state=IDLE, cmd_valid=0, cmd_id=0, cmd_repeat=0, drop=0, repeat timer disarmed.
- Reset mid-offer discards the command in flight.
- Pending set:
  - pb_op[i] sets pending[i] and clears pend_rep[i].
  - A repeat tick for channel i sets pending[i] and sets pend_rep[i], but only if pending[i] was 0.
- Pending clear: pending[i] clears when it is granted (IDLE->OFFER load).
- Set and grant on the same channel in the same cycle: set wins, pending[i] stays 1 and nothing is dropped.
- Drop rule:
  - pb_op[i]=1 while pending[i]=1 and not being granted sets drop.
  - A repeat tick onto an already-pending channel is silently discarded and does NOT set drop.
  - drop_clr clears drop; if drop_clr and a new drop occur in the same cycle, set wins.
- FSM IDLE:
  - If any pending bit is set, grant the lowest index j with pending[j], searching circularly from rr_ptr.
  - Register cmd_id=j and cmd_repeat=pend_rep[j], set cmd_valid=1, clear pending[j], go to OFFER.
  - If nothing is pending, stay in IDLE.
- FSM OFFER:
  - cmd_valid=1; cmd_id and cmd_repeat are held stable.
  - On cmd_ready=1: cmd_valid drops next cycle, rr_ptr = (cmd_id+1) mod N (wraps at N-1 -> 0), go to IDLE.
  - No back-to-back offers; at least one IDLE cycle separates commands.
- Latency:
  - pb_op high in cycle t -> pending at t+1 -> cmd_valid at t+2.
  - cmd_ready in cycle u -> next cmd_valid no earlier than u+2.
- Repeat timer (one shared timer):
  - Any pb_op pulse arms it on the lowest set index k: rep_id=k, count=REPEAT_DELAY.
  - While armed and pb_db[rep_id]=1, count decrements each cycle. When it reaches 1, emit a repeat tick for rep_id and reload REPEAT_PERIOD.
  - pb_db[rep_id]=0 disarms the timer immediately (same edge), with no tick.
  - A new pb_op on any channel re-arms the timer, pre-empting the current channel.
  - REPEAT_DELAY=0: the timer never arms.
- Width: the counter is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits wide, unsigned, never underflows.

Decomposition:
- Shared package/include holds:
  - FSM state localparams ST_IDLE=1'b0, ST_OFFER=1'b1.
  - The default REPEAT_DELAY/REPEAT_PERIOD constants, shared with the debounce clock-divider settings.
- Sub-module repeat_timer (inputs: clk, rst, arm, arm_id, hold level; outputs: tick, rep_id). It holds the counter and arm logic.
- The round-robin pick stays as a combinational function inside the top level.

Test Plan (bench uses N=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Reset release, pb_op=4'b0100 at t=0, cmd_ready=1 -> cmd_valid=1 with cmd_id=2, cmd_repeat=0 at t=2; cmd_valid=0 at t=3; rr_ptr=3.
- pb_op=4'b1011 in one cycle, rr_ptr=3, cmd_ready always 1 -> grants in order id 3, 0, 1, with one idle cycle between each.
- Hold cmd_ready=0 for 10 cycles during OFFER with id=1 -> cmd_id stays 1 and cmd_valid stays 1; a second pb_op[1] in that window leaves pending[1]=1 and does not set drop. A third pb_op[1] while pending[1]=1 -> drop=1; drop_clr -> drop=0 next cycle.
- pb_op[0] pulse, then pb_db[0] held for 20 cycles, cmd_ready=1 -> fresh command id 0, then repeat commands (cmd_repeat=1) with ticks at +8, +12, +16, +20; releasing pb_db[0] -> no further ticks.
- Hold pb_db[2], press pb_op[1] after 5 cycles -> timer re-arms on channel 1; no repeat tick for channel 2.
- Assert rst while cmd_valid=1 with pending=4'b0110 -> all outputs and state return to reset values immediately; after rst falls, no command issues without a new pb_op.
